mem_ctrl_sched: RTL

- Cycle-level scheduler for the board's two external SRAMs and the UART that shares the SRAM1 data bus.
- SRAM2 (addr < 0x8000) holds instructions and data.
  - Instruction fetch owns SRAM2 by default.
  - A data access to SRAM2 stalls fetch for its duration.
- SRAM1 (addr >= 0x8000) and the UART (0xBF00 data, 0xBF01 status) serve data accesses only.
- Sits between the IF/MEM pipeline stages and the board pins; it replaces ad-hoc combinational strobe generation with sequenced, glitch-free strobes.

---
 rtl/mem_ctrl_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_ctrl_sched.sv
// Cycle-level scheduler for SRAM2 (fetch + data), SRAM1 and the UART sharing the SRAM1 bus.
// Pin strobes decode the registered state, so they only change just after a clock edge.
module mem_ctrl_sched #(
    parameter int unsigned       ADDR_W    = 18,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RAM1_BASE = 18'h08000,
    parameter logic [ADDR_W-1:0] UART_DATA = 18'h0BF00,
    parameter logic [ADDR_W-1:0] UART_STAT = 18'h0BF01
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              mem_stall,
    inout  wire  [DATA_W-1:0] sram1_data,
    output logic [ADDR_W-1:0] sram1_addr,
    output logic              sram1_en,
    output logic              sram1_oe,
    output logic              sram1_we,
    inout  wire  [DATA_W-1:0] sram2_data,
    output logic [ADDR_W-1:0] sram2_addr,
    output logic              sram2_en,
    output logic              sram2_oe,
    output logic              sram2_we,
    output logic              rdn,
    output logic              wrn,
    input  logic              data_ready,
    input  logic              tbre,
    input  logic              tsre
);

    typedef enum logic [3:0] {
        StIdle, StStat, StRRd1, StRRd2, StRWs, StRWp, StRWh,
        StURd1, StURd2, StUWp, StUWh, StUWait
    } state_e;

    state_e            state_q;
    logic              tgt_q;    // 1: access targets SRAM1, 0: SRAM2
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic ram_rd, ram_wr, ram1_acc, ram2_acc, drive1, drive2, req_live;

    // The ack cycle still sees the old request held, so it must not start a new access.
    assign req_live  = mem_req & ~mem_ack;
    assign mem_stall = mem_req & ~mem_ack;

    assign sram1_data = drive1 ? wdata_q : {DATA_W{1'bz}};
    assign sram2_data = drive2 ? wdata_q : {DATA_W{1'bz}};

    always_comb begin
        ram_rd   = (state_q == StRRd1) || (state_q == StRRd2);
        ram_wr   = (state_q == StRWs) || (state_q == StRWp) || (state_q == StRWh);
        ram1_acc = (ram_rd || ram_wr) && tgt_q;
        ram2_acc = (ram_rd || ram_wr) && !tgt_q;
        drive1   = (ram_wr && tgt_q) || (state_q == StUWp) || (state_q == StUWh);
        drive2   = ram_wr && !tgt_q;
        if_stall = ram2_acc || ((state_q == StIdle) && req_live && (mem_addr < RAM1_BASE));

        sram1_addr = addr_q;
        sram1_en   = ~ram1_acc;
        sram1_oe   = ~(ram1_acc && ram_rd);
        sram1_we   = ~(tgt_q && (state_q == StRWp));
        // Fetch owns SRAM2 whenever a data access is not using it.
        sram2_addr = ram2_acc ? addr_q : pc;
        sram2_en   = 1'b0;
        sram2_oe   = ram2_acc && ram_wr;
        sram2_we   = ~(!tgt_q && (state_q == StRWp));
        rdn        = ~((state_q == StURd1) || (state_q == StURd2));
        wrn        = ~(state_q == StUWp);
        if (rst) begin
            {sram1_en, sram1_oe, sram1_we, sram2_en, sram2_oe, sram2_we, rdn, wrn} = 8'hFF;
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            tgt_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_ack    <= 1'b0;
            mem_rdata  <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            if (if_stall) begin
                inst_valid <= 1'b0;
            end else begin
                inst       <= sram2_data;
                inst_valid <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (req_live) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        we_q    <= mem_we;
                        tgt_q   <= (mem_addr >= RAM1_BASE);
                        if (mem_addr == UART_STAT) begin
                            state_q <= StStat;
                        end else if (mem_addr == UART_DATA) begin
                            state_q <= mem_we ? StUWp : StURd1;
                        end else begin
                            state_q <= mem_we ? StRWs : StRRd1;
                        end
                    end
                end
                StStat: begin
                    if (!we_q) begin
                        mem_rdata <= {{(DATA_W-2){1'b0}}, data_ready, tbre & tsre};
                    end
                    mem_ack <= 1'b1;
                    state_q <= StIdle;
                end
                StRRd1: state_q <= StRRd2;
                StRRd2: begin
                    mem_rdata <= tgt_q ? sram1_data : sram2_data;
                    mem_ack   <= 1'b1;
                    state_q   <= StIdle;
                end
                StRWs: state_q <= StRWp;
                StRWp: state_q <= StRWh;
                StRWh: begin
                    mem_ack <= 1'b1;
                    state_q <= StIdle;
                end
                StURd1: state_q <= StURd2;
                StURd2: begin
                    mem_rdata <= {{(DATA_W-8){1'b0}}, sram1_data[7:0]};
                    mem_ack   <= 1'b1;
                    state_q   <= StIdle;
                end
                StUWp: state_q <= StUWh;
                StUWh: state_q <= StUWait;
                StUWait: begin
                    if (tbre && tsre) begin
                        mem_ack <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
